muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It takes the same two 32-bit operands the ALU takes, and returns results through HI/LO rather than a single-cycle d_out. A start/busy/done handshake lets the pipeline stall while an iterative shift-add multiply or restoring divide runs.

Parameters:
DATA_W, 32, operand and HI/LO width. Only 32 is verified; iteration count equals DATA_W.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  launch operation selected by md_op; accepted only when busy==0
md_op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
data1  input  32  multiplicand / dividend (rs), sampled on accepted start
data2  input  32  multiplier / divisor (rt), sampled on accepted start
we_hi  input  1  MTHI write strobe
we_lo  input  1  MTLO write strobe
wdata  input  32  MTHI/MTLO write data
busy  output  1  operation in flight; pipeline stalls MFHI/MFLO/MT*/new start
done  output  1  one-cycle pulse when HI/LO take a new result
div_zero  output  1  sticky for last op: divide with data2==0
hi  output  32  HI register (product[63:32] / remainder)
lo  output  32  LO register (product[31:0] / quotient)

Behaviour:
- Reset (rst=1 at an edge) forces state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and clears internal accumulators. This applies in any state; an aborted operation never writes HI/LO.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on start && !busy.
  - RUN -> FIX after exactly DATA_W iterations, with a 5-bit counter counting 0..31.
  - FIX -> IDLE unconditionally.
- Accept edge E0:
  - latch md_op;
  - signed ops latch the magnitudes |data1| and |data2|, unsigned ops latch the raw values;
  - latch result signs: quotient sign = s1^s2, remainder sign = s1, product sign = s1^s2;
  - update div_zero = (md_op[1] && data2==0).
- busy=1 from after E0 through the FIX cycle (33 cycles). busy is 0 and done=1 in the cycle after the FIX edge; done is high for one cycle only.
- Multiply: 64-bit shift-add, one multiplier bit per RUN cycle. FIX negates the 64-bit product if the sign bit is set. Writes hi=P[63:31+1], lo=P[31:0].
- Divide: restoring, one quotient bit per RUN cycle. FIX negates the quotient and/or remainder per the latched signs. Writes lo=quotient, hi=remainder; the remainder sign follows the dividend.
- Signed -2^31 / -1: lo=0x80000000, hi=0. This falls out of the magnitude method with 32-bit truncation; no exception is raised.
- Divide by zero: the operation runs full latency; hi/lo are NOT written; done still pulses; div_zero=1 until the next accepted start.
- start while busy: ignored with no side effects. Operands must not be re-sampled.
- MTHI/MTLO:
  - while IDLE: the write takes effect at that edge;
  - while busy: ignored;
  - simultaneous start && we_hi/we_lo in IDLE: the MT write lands at E0, and the later FIX overwrites it unless divide-by-zero.
- hi/lo are registered outputs and hold their value between writes. MFHI/MFLO read them directly when busy==0.
- The arithmetic has no overflow output; multiply is exact in 64 bits.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at E0 -> busy high 33 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- With hi=0x11, lo=0x22, DIVU 5/0 -> done after 33 cycles, div_zero=1, hi=0x11, lo=0x22 unchanged; the next accepted start clears div_zero.
- start and we_lo pulsed mid-RUN -> both ignored, result matches the original operands. MTLO 0xABCD in IDLE -> lo=0xABCD next cycle.
- rst asserted at RUN iteration 10 -> next cycle busy=0, hi=lo=0, no done pulse. A fresh MULTU 3*5 then gives lo=15, hi=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Pipeline-to-muldiv handshake and HI/LO access bundle.
// The pipeline is the master; muldiv_unit is the slave.
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        md_op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              we_hi;
    logic              we_lo;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, md_op, data1, data2, we_hi, we_lo, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, md_op, data1, data2, we_hi, we_lo, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Uses shift-add multiply and restoring divide on magnitudes, with the sign fixed up in the FIX state.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   r_operand;    // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_is_div;
    logic                r_neg_main;
    logic                r_neg_rem;
    logic                r_div_zero;
    logic                r_done;

    logic                w_accept;
    logic                w_signed;
    logic                w_s1;
    logic                w_s2;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_trial;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [2*DATA_W-1:0] w_div_next;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_signed = ~bus.md_op[0];
    assign w_s1     = w_signed & bus.data1[DATA_W-1];
    assign w_s2     = w_signed & bus.data2[DATA_W-1];
    assign w_mag1   = w_s1 ? -bus.data1 : bus.data1;
    assign w_mag2   = w_s2 ? -bus.data2 : bus.data2;

    // Shift-add: add the multiplicand into the upper half when the current multiplier bit is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and keep the difference only if it is non-negative.
    assign w_div_trial = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]} - {1'b0, r_operand};
    assign w_div_next  = w_div_trial[DATA_W] ? {r_acc[2*DATA_W-2:0], 1'b0}
                                             : {w_div_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

    assign w_prod = r_neg_main ? -r_acc : r_acc;
    assign w_quot = r_neg_main ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_rem  ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned and no latch is inferred.
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == CNT_W'(DATA_W-1)) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.we_hi) r_hi <= bus.wdata;
                    if (bus.we_lo) r_lo <= bus.wdata;
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_is_div   <= bus.md_op[1];
                        r_neg_main <= w_s1 ^ w_s2;
                        r_neg_rem  <= w_s1;
                        r_div_zero <= bus.md_op[1] && (bus.data2 == '0);
                        r_acc      <= {{DATA_W{1'b0}}, bus.md_op[1] ? w_mag1 : w_mag2};
                        r_operand  <= bus.md_op[1] ? w_mag2 : w_mag1;
                    end
                end
                RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (!r_div_zero) begin
                        r_lo <= w_quot;
                        r_hi <= w_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed HI/LO results, latency, handshake and reset cases.
module tb_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    muldiv_unit_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op; returns at the first negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.data1 = d1;
        bus.data2 = d2;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts negedges with busy high, bounded; leaves time at the first negedge with busy low.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        issue(op, d1, d2);
        wait_idle(c);
        check({tag, " latency"}, 32'(c), 32'd33);
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " lo"}, bus.lo, exp_lo);
        @(negedge clk);
        check({tag, " done one-shot"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.md_op = 2'b00;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset div_zero", 32'(bus.div_zero), 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        rst = 1'b0;

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -7*3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        check("div min/-1 div_zero", 32'(bus.div_zero), 32'd0);

        // Divide by zero leaves HI/LO untouched.
        @(negedge clk);
        bus.we_hi = 1'b1;
        bus.wdata = 32'h11;
        @(negedge clk);
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b1;
        bus.wdata = 32'h22;
        @(negedge clk);
        bus.we_lo = 1'b0;
        check("mthi idle", bus.hi, 32'h11);
        check("mtlo idle", bus.lo, 32'h22);
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'h11, 32'h22);
        check("divu 5/0 div_zero", 32'(bus.div_zero), 32'd1);
        issue(OP_MULTU, 32'd2, 32'd3);
        check("div_zero cleared on start", 32'(bus.div_zero), 32'd0);
        wait_idle(cyc);
        check("multu 2*3 lo", bus.lo, 32'd6);
        check("multu 2*3 hi", bus.hi, 32'd0);

        // start and MTLO during RUN are ignored.
        issue(OP_MULTU, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = OP_DIVU;
        bus.data1 = 32'd1;
        bus.data2 = 32'd0;
        bus.we_lo = 1'b1;
        bus.wdata = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        bus.we_lo = 1'b0;
        wait_idle(cyc);
        check("midrun latency", 32'(cyc), 32'd27);
        check("midrun lo", bus.lo, 32'd42);
        check("midrun hi", bus.hi, 32'd0);
        check("midrun div_zero", 32'(bus.div_zero), 32'd0);

        // MTLO simultaneous with a divide-by-zero start lands and survives.
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = OP_DIVU;
        bus.data1 = 32'd9;
        bus.data2 = 32'd0;
        bus.we_lo = 1'b1;
        bus.wdata = 32'h55;
        @(negedge clk);
        bus.start = 1'b0;
        bus.we_lo = 1'b0;
        wait_idle(cyc);
        check("start+mtlo div0 lo", bus.lo, 32'h55);
        check("start+mtlo div0 div_zero", 32'(bus.div_zero), 32'd1);

        @(negedge clk);
        bus.we_lo = 1'b1;
        bus.wdata = 32'hABCD;
        @(negedge clk);
        bus.we_lo = 1'b0;
        check("mtlo abcd", bus.lo, 32'h0000_ABCD);

        // Reset at RUN iteration 10 aborts without writing.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        check("abort div_zero", 32'(bus.div_zero), 32'd0);
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0) cyc++;
        end
        check("abort no done", 32'(cyc), 32'd0);

        run_op("multu 3*5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
